// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
//   Shared definitions for the UART TX scheduler: FSM state encoding,
//   default parameter values and the burst-length decode (0 means 16).
package uart_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_e;

  localparam int NREQ_DEF = 4;
  localparam int TMO_DEF  = 1024;

  // cfg_burst_max is 4 bits wide, so a zero setting stands for the
  // longest burst rather than an empty one.
  localparam logic [4:0] BURST_ZERO_LEN = 5'd16;

  function automatic logic [4:0] burst_decode(input logic [3:0] cfg);
    return (cfg == 4'd0) ? BURST_ZERO_LEN : {1'b0, cfg};
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational round-robin picker. Scans the request vector starting
//   at the requester after last_i and reports the first one asserted.
// Ports
//   req_i    in  NREQ         request vector
//   last_i   in  clog2(NREQ)  previous winner
//   winner_o out clog2(NREQ)  chosen requester (0 when none found)
//   found_o  out 1            at least one request asserted
module uart_rr_pick
  import uart_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [$clog2(NREQ)-1:0] winner_o,
  output logic                    found_o
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] cand;

  // Offsets run 1..NREQ so the previous winner is considered last; it can
  // still win again when it is the only requester.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_i) + k) % NREQ);
      if (!found_o && req_i[cand]) begin
        winner_o = cand;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Arbitrates NREQ byte streams onto a single UART TX byte handshake.
//   A round-robin winner owns the TX path until it sends a byte flagged
//   last or reaches the per-grant burst limit. The datapath through the
//   owner is combinational, so the first byte is offered the cycle after
//   the grant is taken.
//
//   Build option: define UART_TX_SCHED_TIMEOUT_EN to add a stall timer that
//   revokes a grant whose owner holds req_valid low for TMO_CYCLES
//   consecutive cycles. Without it timeout_evt is tied low.
//
// Ports
//   app_clk        in  1       clock, rising edge
//   reset_n        in  1       synchronous active-low reset
//   cfg_enable     in  1       allow new grants
//   cfg_burst_max  in  4       bytes per grant, 0 = 16 (latched at grant)
//   req_valid      in  NREQ    per-requester byte valid
//   req_data       in  8*NREQ  per-requester byte, requester i at [8i+7:8i]
//   req_last       in  NREQ    last byte of message
//   req_ready      out NREQ    byte accepted (owner only)
//   tx_valid       out 1       byte offered to TX core
//   tx_data        out 8       byte to TX core
//   tx_ready       in  1       TX core accepts
//   grant_id       out 2       current / most recent owner
//   busy           out 1       grant active
//   timeout_evt    out 1       one-cycle pulse on stall-timeout revocation
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid requesters when enabled
// XFER  | grant_id owns the TX path until last byte, burst limit, timeout
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int TMO_CYCLES = TMO_DEF
) (
  input  logic              app_clk,
  input  logic              reset_n,
  input  logic              cfg_enable,
  input  logic [3:0]        cfg_burst_max,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int IDW = 2;

  // grant_id is a fixed 2-bit port, so only four requesters are supported.
  if (NREQ != 4 || TMO_CYCLES < 1) begin : g_param_check
    $error("uart_tx_sched: NREQ must be 4 and TMO_CYCLES at least 1");
  end

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_q, last_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [4:0]     lim_q, lim_d;

  logic [IDW-1:0] pick_winner;
  logic           pick_found;
  logic [7:0]     data_arr [NREQ];
  logic           sel_valid;
  logic           sel_last;
  logic [7:0]     sel_data;
  logic           xfer;
  logic           tmo_hit;

  for (genvar g = 0; g < NREQ; g++) begin : g_data_split
    assign data_arr[g] = req_data[8*g +: 8];
  end

  uart_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i    (req_valid),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .found_o  (pick_found)
  );

  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign sel_data  = data_arr[grant_q];

  assign busy     = (state_q == XFER);
  assign grant_id = grant_q;
  assign tx_valid = busy & sel_valid;
  assign tx_data  = busy ? sel_data : 8'h00;
  assign xfer     = tx_valid & tx_ready;

  always_comb begin
    req_ready = '0;
    if (busy) begin
      req_ready[grant_q] = tx_ready;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int STW = $clog2(TMO_CYCLES + 1);

  logic [STW-1:0] stall_q, stall_d;
  logic           tmo_evt_q;

  // Counts consecutive owner-invalid cycles; the TMO_CYCLES-th such cycle
  // revokes the grant at the following edge.
  always_comb begin
    stall_d = '0;
    tmo_hit = 1'b0;
    if (busy && !sel_valid) begin
      if (stall_q == STW'(TMO_CYCLES - 1)) begin
        tmo_hit = 1'b1;
      end else begin
        stall_d = stall_q + STW'(1);
      end
    end
  end

  always_ff @(posedge app_clk) begin
    if (!reset_n) begin
      stall_q   <= '0;
      tmo_evt_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      tmo_evt_q <= tmo_hit;
    end
  end

  assign timeout_evt = tmo_evt_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable && pick_found) begin
          state_d = XFER;
          grant_d = pick_winner;
          cnt_d   = '0;
          lim_d   = burst_decode(cfg_burst_max);
        end
      end
      XFER: begin
        if (xfer) begin
          cnt_d = cnt_q + 5'd1;
          // last flag and burst limit on the same byte release only once
          if (sel_last || (cnt_d == lim_q)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      lim_q   <= BURST_ZERO_LEN;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have one clock, app_clk; reset is reset_n, synchronous and active-low.
REQ-002 Parameter NREQ, default 4: number of requesters; fixed at 4 in this revision.
REQ-003 Parameter TMO_CYCLES, default 1024: stall-timeout limit in app_clk cycles.
REQ-004 app_clk  in  1  block clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 cfg_enable  in  1  1 = arbitration allowed; 0 = no new grants.
REQ-007 cfg_burst_max  in  4  max bytes per grant; 0 encodes 16.
REQ-008 req_valid  in  NREQ  per-requester byte valid.
REQ-009 req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-010 req_last  in  NREQ  per-requester last-byte-of-message flag, qualified by req_valid.
REQ-011 req_ready  out  NREQ  per-requester byte accepted.
REQ-012 tx_valid / tx_data / tx_ready  out 1 / out 8 / in 1  byte handshake to the UART TX core.
REQ-013 grant_id  out  2  index of the current owner.
REQ-014 busy  out  1  1 while in XFER.
REQ-015 timeout_evt  out  1  one-cycle pulse when a grant is revoked by the stall timeout.

Function
REQ-016 FSM states SHALL be IDLE and XFER.
REQ-017 IDLE: if cfg_enable=1 and any req_valid=1, the scheduler SHALL pick a winner by round-robin, register it in grant_id, clear the byte counter and enter XFER on the next edge.
  - Search order starts at (last_winner+1) mod NREQ.
  - last_winner resets to NREQ-1, so requester 0 has priority first.
REQ-018 XFER datapath SHALL be combinational:
  - tx_valid = req_valid[grant_id]; tx_data = req_data[grant_id].
  - req_ready[grant_id] = tx_ready.
  - All other req_ready bits SHALL be 0.
REQ-019 Latency: the first byte SHALL appear on tx_valid exactly one cycle after the IDLE cycle that sampled the request.
REQ-020 A transfer is tx_valid & tx_ready; each transfer SHALL increment a 5-bit byte counter.
REQ-021 On a transfer with req_last=1, or when the counter reaches the burst limit (cfg_burst_max, or 16 if 0), the FSM SHALL:
  - return to IDLE next cycle;
  - set last_winner = grant_id.
REQ-022 When req_last and the burst limit coincide, the FSM SHALL release once, with identical behaviour.
REQ-023 A requester deasserting req_valid in XFER SHALL keep the grant; tx_valid then follows req_valid low.
REQ-024 cfg_enable deasserted in XFER SHALL NOT abort the grant; the current burst completes, then no new grant is issued.
REQ-025 cfg_burst_max changes SHALL take effect only at the next grant (latched on entry to XFER).
REQ-026 IDLE SHALL hold tx_valid=0, req_ready=0 and busy=0; grant_id keeps its last value.
REQ-027 Because one grant is released before the next is issued, there SHALL be at least one IDLE cycle between grants.

Reset
REQ-028 While reset_n=0 at an edge, the block SHALL force:
  - state IDLE, counter 0, last_winner NREQ-1;
  - grant_id 0, busy 0, timeout_evt 0, and hence tx_valid=0, req_ready=0.
REQ-029 Reset mid-XFER SHALL drop the grant with no further handshake.

Configuration
REQ-030 Macro UART_TX_SCHED_TIMEOUT_EN defined:
  - in XFER, a stall counter SHALL count consecutive cycles with req_valid[grant_id]=0 and clear on any cycle with it 1;
  - on reaching TMO_CYCLES it SHALL force IDLE, set last_winner=grant_id and pulse timeout_evt for one cycle.
REQ-031 Macro undefined: the stall counter SHALL be absent; timeout_evt SHALL be tied to 0; the port list SHALL be unchanged.

Structure
REQ-032 A shared package uart_sched_pkg SHALL hold:
  - the state enum (IDLE, XFER);
  - NREQ_DEF=4, TMO_DEF=1024;
  - the burst-decode constant for 0→16.
REQ-033 Sub-module uart_rr_pick SHALL be purely combinational: inputs request vector and last_winner; outputs winner index and found.

Verification
REQ-034 Single message: req 2 sends 0x41,0x42,0x43 with last on 0x43, tx_ready=1 → tx_data 41,42,43 on three consecutive cycles starting one cycle after the request, grant_id=2, then IDLE.
REQ-035 Round-robin: all four requesters hold single-byte last messages continuously → grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-036 Burst limit: cfg_burst_max=2, req 1 streams 5 bytes without last, req 3 pending → order 2 bytes req1, 1 byte req3, 2 bytes req1, then 1 byte req1.
REQ-037 Backpressure: tx_ready low for 7 cycles mid-message → tx_data held stable, req_ready[grant]=0, no byte lost or duplicated.
REQ-038 Reset mid-XFER: reset_n=0 for 1 cycle after byte 2 of 4 → next cycle busy=0, tx_valid=0, grant_id=0; requester 0 wins the next arbitration.
REQ-039 Timeout (macro defined, TMO_CYCLES=8): granted requester drops req_valid → after 8 cycles timeout_evt pulses once and the next requester is granted; with the macro undefined, the grant is held indefinitely.
